// File: rtl/game_controller.sv
// Game sequencer: synchronises the divisor's slow clock into a play-only tick, runs the round FSM and tracks score/timer.
// Optional feature: define HIGH_SCORE_EN to build the high_score register (tied to 0 otherwise).
module game_controller #(
  parameter int GAME_TIME = 60,
  parameter int SCORE_MAX = 99,
  parameter int SCORE_W   = 8,
  parameter int TIME_W    = 7
) (
  input  logic               clk_i,
  input  logic               rst_n_i,
  input  logic               slow_clk_i,
  input  logic               start_btn_i,
  input  logic               pause_btn_i,
  input  logic               speed_btn_i,
  input  logic               hit_i,
  output logic [2:0]         state_o,
  output logic               switch_o,
  output logic               tick_o,
  output logic [TIME_W-1:0]  time_left_o,
  output logic [SCORE_W-1:0] score_o,
  output logic [SCORE_W-1:0] high_score_o
);

  typedef enum logic [2:0] {
    IDLE  = 3'b000,
    PLAY  = 3'b001,
    STOP  = 3'b010,
    SCORE = 3'b011,
    SPEED = 3'b100
  } state_e;

  localparam logic [TIME_W-1:0]  TIME_LOAD = TIME_W'(GAME_TIME);
  localparam logic [SCORE_W-1:0] SCORE_CAP = SCORE_W'(SCORE_MAX);

  state_e             state_q, state_d;
  logic               s1_q, s2_q, s3_q;
  logic               tick_q;
  logic               switch_q, switch_d;
  logic [TIME_W-1:0]  time_q, time_d;
  logic [SCORE_W-1:0] score_q, score_d;
  logic               rise;

  function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] v);
    if (v >= SCORE_CAP) return SCORE_CAP;
    return v + SCORE_W'(1);
  endfunction

  assign rise = s2_q & ~s3_q;

  always_comb begin
    state_d  = state_q;
    switch_d = switch_q;
    time_d   = time_q;
    score_d  = score_q;
    case (state_q)
      IDLE: begin
        if (start_btn_i) begin
          state_d = PLAY;
          time_d  = TIME_LOAD;
          score_d = '0;
        end else if (speed_btn_i) begin
          state_d = SPEED;
        end
      end
      PLAY: begin
        if (hit_i) score_d = sat_inc(score_q);
        if (tick_q && time_q != '0) time_d = time_q - TIME_W'(1);
        // Expiry wins over a coincident pause so a round can never stall at zero.
        if (tick_q && time_q == TIME_W'(1)) state_d = SCORE;
        else if (pause_btn_i)               state_d = STOP;
      end
      STOP: begin
        if (start_btn_i)      state_d = IDLE;
        else if (pause_btn_i) state_d = PLAY;
      end
      SCORE: begin
        if (start_btn_i) state_d = IDLE;
      end
      SPEED: begin
        if (start_btn_i)      state_d = IDLE;
        else if (speed_btn_i) switch_d = ~switch_q;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q  <= IDLE;
      s1_q     <= 1'b0;
      s2_q     <= 1'b0;
      s3_q     <= 1'b0;
      tick_q   <= 1'b0;
      switch_q <= 1'b0;
      time_q   <= '0;
      score_q  <= '0;
    end else begin
      s1_q     <= slow_clk_i;
      s2_q     <= s1_q;
      s3_q     <= s2_q;
      tick_q   <= rise & (state_q == PLAY);
      state_q  <= state_d;
      switch_q <= switch_d;
      time_q   <= time_d;
      score_q  <= score_d;
    end
  end

`ifdef HIGH_SCORE_EN
  logic [SCORE_W-1:0] hs_q;
  // Compare against the final score, so a hit on the last tick is included.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      hs_q <= '0;
    end else if (state_q == PLAY && state_d == SCORE && score_d > hs_q) begin
      hs_q <= score_d;
    end
  end
  assign high_score_o = hs_q;
`else
  assign high_score_o = '0;
`endif

  assign state_o     = state_q;
  assign switch_o    = switch_q;
  assign tick_o      = tick_q;
  assign time_left_o = time_q;
  assign score_o     = score_q;

endmodule

// File: doc/game_controller.md
# game_controller

Top-level game sequencer downstream of the clock divisor. It consumes the divisor's slow game clock as a synchronised, edge-detected tick enable in the system clock domain. It runs the idle/play/stop/score/speed state machine, counts the play timer and score, and drives `state` and `switch` back into the divisor to select the fast or normal tick rate.

## Interface
Parameters:
- `GAME_TIME`, 60: play-round length in ticks; loaded into `time_left` on round start.
- `SCORE_MAX`, 99: saturation value of `score`.
- `SCORE_W`, 8: width of `score` and `high_score`.
- `TIME_W`, 7: width of `time_left`; must hold `GAME_TIME`.

Ports:
- `clk` input 1: system clock; all logic on posedge.
- `rst_n` input 1: reset, synchronous, active-low.
- `slow_clk` input 1: divisor slow output, level signal; treated as asynchronous data.
- `start_btn` input 1: one-cycle pulse, debounced upstream.
- `pause_btn` input 1: one-cycle pulse.
- `speed_btn` input 1: one-cycle pulse.
- `hit` input 1: one-cycle pulse from game logic; adds 1 point.
- `state` output 3: current state; idle=000, play=001, stop=010, score=011, speed=100.
- `switch` output 1: 1 selects the fast divisor rate.
- `tick` output 1: one-cycle pulse per `slow_clk` rising edge; only asserted in play.
- `time_left` output TIME_W: remaining ticks.
- `score` output SCORE_W: current score.
- `high_score` output SCORE_W: best score; see Configuration.

## Operation
- Synchroniser: `slow_clk` passes through 2 flops (`s1`, `s2`), then an edge flop `s3`.
  - `rise = s2 & ~s3`.
  - Registered `tick <= rise & (state==play)`.
- State transitions (button priority when several pulse together: start > pause > speed):
  - idle: start → play; load `time_left=GAME_TIME`, `score=0`. speed → speed.
  - play: pause → stop. start is ignored.
    - On `tick`, `time_left` decrements.
    - On `tick` with `time_left==1`: `time_left` becomes 0 and state becomes score on the same edge.
  - stop: pause → play; the timer resumes from its held value. start → idle (abort); `score` and `time_left` hold until the next round start.
  - score: start → idle.
  - speed: speed toggles `switch`. start → idle.
  - All other button pulses in any state are ignored.
- `hit`:
  - Counted only in play; `score <= min(score+1, SCORE_MAX)`.
  - `hit` and `tick` in the same cycle are both applied.
  - A `hit` on the final tick cycle still counts.
- `switch` only changes in the speed state and persists across rounds.
- Reset in any state, mid-round included: all registers return to reset values on the next edge.

## Timing
- Reset values:
  - `state`=idle (000).
  - `switch`=0, `tick`=0, `time_left`=0, `score`=0, `high_score`=0.
  - Synchroniser flops = 0.
- `slow_clk` rise to `tick` high: `tick` asserts on the 3rd `clk` edge after `slow_clk` is first sampled high. It lasts exactly 1 cycle.
- Update latency (registered outputs, no combinational path from input to output):
  - `time_left` and `score` update on the edge after `tick`/`hit` is high.
  - `state` updates on the edge that samples the button.
- Round start: `time_left=GAME_TIME` and `score=0` are visible in the cycle `state` first reads play.
- A `slow_clk` edge that arrives while not in play produces no tick. Entering play does not replay an old edge.

## Configuration
- `HIGH_SCORE_EN` defined:
  - `high_score` register is compiled in.
  - On the edge entering score, if `score > high_score` then `high_score <= score`.
  - Cleared only by reset.
- `HIGH_SCORE_EN` undefined:
  - No register is built; `high_score` is tied to 0.

## Test plan
- Reset: hold `rst_n=0` 2 cycles with random inputs → `state=000`, `switch=0`, `tick=0`, `score=0`, `time_left=0`.
- Full round: GAME_TIME=3, start, 3 `slow_clk` rises, 2 hits →
  - `time_left` 3→2→1→0.
  - `state=011` on the edge after the 3rd tick.
  - `score=2`; `high_score=2` with HIGH_SCORE_EN, 0 without.
- Pause: in play pulse pause, then 2 `slow_clk` rises → `state=010`, `time_left` unchanged, `tick` stays 0. Pulse pause → play resumes the countdown.
- Saturation: SCORE_MAX=99, 105 hits in play → `score=99`. A hit coincident with a tick → both apply.
- Speed menu: idle → speed_btn → `state=100` → speed_btn → `switch=1`. start → idle with `switch` still 1. Start and speed pulsed together in idle → play.
- Reset mid-round: `rst_n=0` for 1 edge while in play with `score=5` → `state=000`, `score=0`, `switch=0`.
